// File: rtl/pc_fetch_unit.sv
// KGP-RISC program counter and instruction-fetch sequencer (FETCH -> WAIT -> ISSUE -> NEXT).
// Optional WAIT-state timeout fault is enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_NEXT  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = 1'b0;
    valid_d = valid_q;
    fault_d = fault_q;
    code_d  = code_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_RESET: begin
        if (!halt) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end
      // A halted FETCH holds req low; once halt drops the request is raised for one cycle.
      S_FETCH: begin
        if (req_q) begin
          state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!halt) begin
          req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          fault_d = 1'b1;
          code_d  = 2'b10;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      S_ISSUE: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (npc_valid) begin
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            state_d = S_FETCH;
            req_d   = !halt;
          end else begin
            fault_d = 1'b1;
            code_d  = 2'b01;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: ;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      code_q  <= code_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit: per-cycle table plus reset/timeout sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4), .npc_valid(npc_valid), .npc(npc),
    .fault(fault), .fault_code(fault_code)
  );

  typedef struct {
    string       name;
    logic        halt, ack;
    logic [31:0] rdata;
    logic        ready, nv;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_fault;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic h, logic a, logic [31:0] rd, logic r, logic v,
                              logic [31:0] np, logic er, logic [31:0] ep, logic ev,
                              logic [31:0] ei, logic [31:0] e4, logic ef, logic [1:0] ec);
    vec_t t;
    t = '{name: n, halt: h, ack: a, rdata: rd, ready: r, nv: v, npc: np, e_req: er, e_pc: ep,
          e_valid: ev, e_instr: ei, e_p4: e4, e_fault: ef, e_code: ec};
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic a, input logic [31:0] rd, input logic r,
                       input logic v, input logic [31:0] np);
    halt = h; imem_ack = a; imem_rdata = rd; instr_ready = r; npc_valid = v; npc = np;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 32'd0);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".pc"}, pc, 32'h0);
    chk({tag, ".instr"}, instr, 32'h0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".code"}, 32'(fault_code), 32'd0);
  endtask

  // Pulse reset away from the clock edge, release with halt low, and advance into WAIT.
  task automatic to_wait();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("to_wait.fetch_req", 32'(imem_req), 32'd1);
    tick();
    chk("to_wait.wait_req", 32'(imem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    //   name          h  a  rdata          r  v  npc            req pc             v  instr          pc+4          f  code
    add("fetch0",      0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,          0, 32'h0,         32'h4,        0, 2'b00);
    add("wait0",       0, 0, 32'h0,         1, 1, 32'h40,        0, 32'h0,          0, 32'h0,         32'h4,        0, 2'b00);
    add("ack0",        0, 1, 32'h1234_5678, 0, 0, 32'h0,         0, 32'h0,          1, 32'h1234_5678, 32'h4,        0, 2'b00);
    add("accept0",     0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          0, 32'h1234_5678, 32'h4,        0, 2'b00);
    add("npc0",        0, 0, 32'h0,         0, 1, 32'h4,         1, 32'h4,          0, 32'h1234_5678, 32'h8,        0, 2'b00);
    add("wait1",       0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,          0, 32'h1234_5678, 32'h8,        0, 2'b00);
    add("ack1",        0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 32'h4,          1, 32'hDEAD_BEEF, 32'h8,        0, 2'b00);
    for (int i = 0; i < 5; i++)
      add("stall",     0, 1, 32'h0BAD_F00D, 0, 1, 32'h8,         0, 32'h4,          1, 32'hDEAD_BEEF, 32'h8,        0, 2'b00);
    add("accept1",     0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4,          0, 32'hDEAD_BEEF, 32'h8,        0, 2'b00);
    add("npc_wrap",    0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,  0, 32'hDEAD_BEEF, 32'h0,        0, 2'b00);
    add("wait_wrap",   0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hFFFF_FFFC,  0, 32'hDEAD_BEEF, 32'h0,        0, 2'b00);
    add("ack_wrap",    0, 1, 32'hA5A5_A5A5, 0, 0, 32'h0,         0, 32'hFFFF_FFFC,  1, 32'hA5A5_A5A5, 32'h0,        0, 2'b00);
    add("accept_wrap", 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hFFFF_FFFC,  0, 32'hA5A5_A5A5, 32'h0,        0, 2'b00);
    add("npc_10",      0, 0, 32'h0,         0, 1, 32'h10,        1, 32'h10,         0, 32'hA5A5_A5A5, 32'h14,       0, 2'b00);
    add("wait3",       0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h10,         0, 32'hA5A5_A5A5, 32'h14,       0, 2'b00);
    add("ack3",        0, 1, 32'h13,        0, 0, 32'h0,         0, 32'h10,         1, 32'h13,        32'h14,       0, 2'b00);
    add("accept3",     0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,         0, 32'h13,        32'h14,       0, 2'b00);
    add("npc_halt",    1, 0, 32'h0,         0, 1, 32'h20,        0, 32'h20,         0, 32'h13,        32'h24,       0, 2'b00);
    add("halted",      1, 1, 32'h0,         0, 0, 32'h0,         0, 32'h20,         0, 32'h13,        32'h24,       0, 2'b00);
    add("unhalt",      0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h20,         0, 32'h13,        32'h24,       0, 2'b00);
    add("wait4",       0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h20,         0, 32'h13,        32'h24,       0, 2'b00);
    add("ack4",        0, 1, 32'h77,        0, 0, 32'h0,         0, 32'h20,         1, 32'h77,        32'h24,       0, 2'b00);
    add("accept4",     0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h20,         0, 32'h77,        32'h24,       0, 2'b00);
    add("misalign",    0, 0, 32'h0,         0, 1, 32'h0000_0102, 0, 32'h20,         0, 32'h77,        32'h24,       1, 2'b01);
    for (int i = 0; i < 4; i++)
      add("fault_hold",0, 1, 32'h99,        1, 1, 32'h30,        0, 32'h20,         0, 32'h77,        32'h24,       1, 2'b01);

    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].halt, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].nv, vecs[i].npc);
      tick();
      chk({vecs[i].name, ".req"},   32'(imem_req),    32'(vecs[i].e_req));
      chk({vecs[i].name, ".pc"},    pc,               vecs[i].e_pc);
      chk({vecs[i].name, ".addr"},  imem_addr,        vecs[i].e_pc);
      chk({vecs[i].name, ".valid"}, 32'(instr_valid), 32'(vecs[i].e_valid));
      chk({vecs[i].name, ".instr"}, instr,            vecs[i].e_instr);
      chk({vecs[i].name, ".pc4"},   pc_plus4,         vecs[i].e_p4);
      chk({vecs[i].name, ".fault"}, 32'(fault),       32'(vecs[i].e_fault));
      chk({vecs[i].name, ".code"},  32'(fault_code),  32'(vecs[i].e_code));
    end

    // Asynchronous reset out of FAULT: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_from_fault");

`ifdef FETCH_TIMEOUT_EN
    to_wait();
    for (int i = 0; i < 15; i++) tick();
    chk("tmo.before", 32'(fault), 32'd0);
    tick();
    chk("tmo.fault", 32'(fault), 32'd1);
    chk("tmo.code", 32'(fault_code), 32'd2);
    to_wait();
    for (int i = 0; i < 15; i++) tick();
    drive(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, '0);
    tick();
    chk("tmo_ack.fault", 32'(fault), 32'd0);
    chk("tmo_ack.valid", 32'(instr_valid), 32'd1);
`else
    to_wait();
    for (int i = 0; i < 40; i++) tick();
    chk("no_tmo.fault", 32'(fault), 32'd0);
    chk("no_tmo.code", 32'(fault_code), 32'd0);
    chk("no_tmo.valid", 32'(instr_valid), 32'd0);
`endif

    // Reset mid-WAIT with halt high at release; a late ack must be ignored.
    to_wait();
    drive(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, '0);
    tick();
    chk("mw.instr", instr, 32'h55);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h8);
    tick();
    chk("mw.pc", pc, 32'h8);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    halt = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid_wait");
    tick();
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_rst.req", 32'(imem_req), 32'd0);
      chk("halted_rst.valid", 32'(instr_valid), 32'd0);
      chk("halted_rst.instr", instr, 32'h0);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("release.req", 32'(imem_req), 32'd1);
    chk("release.addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for KGP-RISC. Holds the architectural PC, issues one request per instruction to instruction memory, and hands the fetched word to decode over a valid/ready handshake. It then waits for the next-PC value from the next-PC selection logic (PC+4 / label / branch target) and loads it. It sits directly upstream of the next-PC logic: it supplies `pc_plus4` and consumes the selected `npc`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 16, cycles allowed in WAIT before a timeout fault (used only with `FETCH_TIMEOUT_EN`).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `halt`  in  1  when high, no new fetch is started.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory has returned data this cycle.
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack` is high.
- `instr_valid`  out  1  `instr` is valid for decode.
- `instr`  out  32  latched instruction word.
- `instr_ready`  in  1  decode accepts `instr`.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, combinational, modulo 2^32.
- `npc_valid`  in  1  `npc` is valid.
- `npc`  in  32  selected next PC.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  01 = misaligned npc, 10 = fetch timeout, 00 = none.

## Operation
- The FSM has six states, encoded in 3 bits: RESET, FETCH, WAIT, ISSUE, NEXT, FAULT.
- RESET: entered asynchronously on `rst`. On the first clock edge with `rst` low it moves to FETCH, or to HALTED-FETCH behaviour (stays in RESET) while `halt` is high.
- FETCH: `imem_req`=1 for exactly one cycle. Always moves to WAIT. If `halt` is high on entry, the FSM stays in FETCH with `imem_req`=0 until `halt` falls.
- WAIT: `imem_req`=0. On `imem_ack`, latch `imem_rdata` into `instr` and move to ISSUE. Acks seen in any other state are ignored.
- ISSUE: `instr_valid`=1.
  - On `instr_valid && instr_ready`, move to NEXT.
  - `instr` must stay stable while `instr_valid` is high and `instr_ready` is low.
- NEXT: wait for `npc_valid`.
  - If `npc[1:0]`==0: `pc` <= `npc`, go to FETCH.
  - Otherwise: `pc` is unchanged, `fault`=1, `fault_code`=01, go to FAULT.
- FAULT: terminal state. All request and valid outputs are 0; only `rst` leaves it.
- `halt` is sampled only in RESET and FETCH. A halt raised mid-instruction lets that instruction complete through NEXT.
- `npc_valid` outside NEXT is ignored.
- `pc` changes only in NEXT (and on reset), so `pc_plus4` is stable for the whole ISSUE/NEXT window.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=0
  - `instr_valid`=0, `imem_req`=0
  - `fault`=0, `fault_code`=00
- Best-case loop is 4 cycles per instruction, with a zero-wait memory (ack the cycle after req) and ready/npc_valid already high: FETCH, WAIT, ISSUE, NEXT.
- `instr` is registered. `instr_valid` is high starting the cycle after the ack edge.
- Asserting `rst` mid-WAIT aborts the fetch. A late `imem_ack` after reset release is ignored because the FSM is not in WAIT.
- PC wrap: `npc`=32'hFFFF_FFFC is legal, and `pc_plus4` then equals 0.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter of width $clog2(`TIMEOUT_CYCLES`+1) clears on entry to WAIT and increments each cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: `fault`=1, `fault_code`=10, go to FAULT.
  - An ack in the same cycle as the count reaching `TIMEOUT_CYCLES` wins, and no fault is raised.
- Undefined: WAIT waits indefinitely, no counter exists, and `fault_code` 10 is never produced.

## Test plan
- Reset with `RESET_PC`=0, ack 1 cycle after req, `imem_rdata`=32'h1234_5678, ready=1, npc=4 -> `imem_addr`=0, `instr`=32'h1234_5678 with valid in cycle 3, `pc`=4 after cycle 4, then `imem_addr`=4.
- Back-pressure: hold `instr_ready`=0 for 5 cycles -> `instr_valid` stays 1, `instr` stays stable, `pc` is unchanged, and no new `imem_req` is issued.
- Misaligned: npc=32'h0000_0102 -> `fault`=1, `fault_code`=01, `pc` keeps its old value, and no further `imem_req` until `rst`.
- Wrap: npc=32'hFFFF_FFFC -> `imem_addr`=32'hFFFF_FFFC and `pc_plus4`=0.
- Timeout (with `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): never ack -> fault with `fault_code`=10 exactly 16 cycles after entering WAIT. Ack on cycle 16 -> no fault.
- Async reset mid-WAIT with `halt`=1 at release -> all outputs return to their reset values immediately, and no `imem_req` is issued until `halt`=0.
